// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl -- single-clock FIFO controller that sequences an external
// dpram (wclk = rclk = clk). It owns the read/write pointers and the occupancy
// count, drives the RAM ports, and exposes a push/pop interface with flags.
//
// Optional feature macro: FIFO_FWFT_EN
//   undefined : standard mode; rd_valid pulses one cycle after an accepted pop
//   defined   : first-word-fall-through; the head word is presented on
//               rd_data/rd_valid without a request, empty = !rd_valid
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   wr_en, wr_data, full, almost_full push side
//   rd_en, rd_data, rd_valid, empty   pop side
//   count                             words held, 0..DEPTH
//   ram_wen, ram_waddr, ram_wdata     dpram write port
//   ram_ren, ram_raddr, ram_rdata     dpram read port (rdata registered, holds when ren=0)
module sync_fifo_ctrl #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int AFULL_TH = 12,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [WIDTH-1:0]  ram_wdata,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [WIDTH-1:0]  ram_rdata
);

  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_TH);

  // Pointers carry one extra bit so a full RAM (wr_ptr - rd_ptr == DEPTH)
  // is distinguishable from an empty one.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] count_q;
  logic            full_q;
  logic            afull_q;
  logic            rd_valid_q;

  logic            wpush;
  logic            pop;
  logic            rd_fetch;
  logic            rd_valid_nxt;
  logic [ADDR_W:0] wr_ptr_nxt;
  logic [ADDR_W:0] rd_ptr_nxt;
  logic [ADDR_W:0] count_nxt;

  // full is the registered flag, so a push offered while full is dropped
  // even if a pop frees a slot in the same cycle.
  assign wpush = wr_en & ~full_q;

`ifdef FIFO_FWFT_EN
  // Words still sitting in the RAM (the head word, once fetched, lives in
  // the dpram output register and is tracked by rd_valid instead).
  logic [ADDR_W:0] m;

  assign m            = wr_ptr - rd_ptr;
  assign pop          = rd_en & rd_valid_q;
  // Refill the output register whenever it is empty or being consumed, so
  // back-to-back pops run at one word per cycle.
  assign rd_fetch     = (m != '0) & (~rd_valid_q | pop);
  assign rd_valid_nxt = rd_fetch ? 1'b1 : (pop ? 1'b0 : rd_valid_q);
  assign empty        = ~rd_valid_q;
`else
  logic empty_q;

  assign pop          = rd_en & ~empty_q;
  assign rd_fetch     = pop;
  assign rd_valid_nxt = pop;
  assign empty        = empty_q;
`endif

  assign wr_ptr_nxt = wr_ptr + (ADDR_W+1)'(wpush);
  assign rd_ptr_nxt = rd_ptr + (ADDR_W+1)'(rd_fetch);

  // Occupancy is derived from the pointers; in FWFT mode the prefetched head
  // word has already left the RAM but is still owned by the FIFO. This is
  // equivalent to +1 on push / -1 on pop.
`ifdef FIFO_FWFT_EN
  assign count_nxt = (wr_ptr_nxt - rd_ptr_nxt) + (ADDR_W+1)'(rd_valid_nxt);
`else
  assign count_nxt = wr_ptr_nxt - rd_ptr_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count_q    <= count_nxt;
      full_q     <= (count_nxt == FULL_CNT);
      afull_q    <= (count_nxt >= AFULL_CNT);
      rd_valid_q <= rd_valid_nxt;
    end
  end

`ifndef FIFO_FWFT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      empty_q <= 1'b1;
    end else begin
      empty_q <= (count_nxt == '0);
    end
  end
`endif

  // A read is only issued for a slot holding data and a write only for a
  // free slot, so the two addresses never collide in one cycle.
  assign ram_wen     = wpush;
  assign ram_waddr   = wr_ptr[ADDR_W-1:0];
  assign ram_wdata   = wr_data;
  assign ram_ren     = rd_fetch;
  assign ram_raddr   = rd_ptr[ADDR_W-1:0];

  assign rd_data     = ram_rdata;
  assign rd_valid    = rd_valid_q;
  assign count       = count_q;
  assign full        = full_q;
  assign almost_full = afull_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       almost_full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic [4:0] count;
  logic       ram_wen;
  logic [3:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic       ram_ren;
  logic [3:0] ram_raddr;
  logic [7:0] ram_rdata;

  int checks;
  int passed;

  // model state
  int         mcnt;
  logic [3:0] mwptr;
  logic [3:0] mrptr;
  logic [7:0] stored[$];   // words the model believes are held
  logic [7:0] exp_out[$];  // scoreboard: words expected on rd_data

  sync_fifo_ctrl #(.DEPTH(16), .WIDTH(8), .AFULL_TH(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .count(count),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  // dpram: registered read with 1-cycle latency, output holds when ren=0
  logic [7:0] mem [16];
  initial ram_rdata = 8'h00;
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags();
    chk("count", 32'(count), 32'(mcnt));
    chk("full", 32'(full), 32'(mcnt == 16));
    chk("almost_full", 32'(almost_full), 32'(mcnt >= 12));
    chk("empty", 32'(empty), 32'(mcnt == 0));
  endtask

  // One standard-mode cycle: drive, check RAM-port strobes before the edge,
  // update the model, then check registered outputs just after the edge.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic re);
    logic push_ok;
    logic pop_ok;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    push_ok = we && (mcnt < 16);
    pop_ok  = re && (mcnt > 0);
    #3;
    chk("ram_wen", 32'(ram_wen), 32'(push_ok));
    if (push_ok) chk("ram_waddr", 32'(ram_waddr), 32'(mwptr));
    chk("ram_ren", 32'(ram_ren), 32'(pop_ok));
    if (pop_ok) chk("ram_raddr", 32'(ram_raddr), 32'(mrptr));
    if (pop_ok) begin
      exp_out.push_back(stored.pop_front());
      mrptr = mrptr + 4'd1;
      mcnt  = mcnt - 1;
    end
    if (push_ok) begin
      stored.push_back(wd);
      mwptr = mwptr + 4'd1;
      mcnt  = mcnt + 1;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(pop_ok));
    if (rd_valid === 1'b1 && exp_out.size() > 0) chk("rd_data", 32'(rd_data), 32'(exp_out.pop_front()));
    chk_flags();
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    mcnt    = 0;
    mwptr   = 4'd0;
    mrptr   = 4'd0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;
    #12;
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk_flags();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef FIFO_FWFT_EN
    // push 0x5A in cycle N, head appears at N+2 without rd_en
    wr_en = 1'b1; wr_data = 8'h5A; exp_out.push_back(8'h5A);
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk("fw_n1_valid", 32'(rd_valid), 32'd0);
    chk("fw_n1_count", 32'(count), 32'd1);
    @(posedge clk); #1;
    chk("fw_n2_valid", 32'(rd_valid), 32'd1);
    chk("fw_n2_data", 32'(rd_data), 32'h5A);
    chk("fw_n2_empty", 32'(empty), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1'b1; wr_data = 8'hB0 + 8'(i); exp_out.push_back(8'hB0 + 8'(i));
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("fw_count4", 32'(count), 32'd4);
    chk("fw_head_hold", 32'(rd_data), 32'h5A);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("fw_pop_valid", 32'(rd_valid), 32'd1);
      if (exp_out.size() > 0) chk("fw_pop_data", 32'(rd_data), 32'(exp_out.pop_front()));
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    chk("fw_end_empty", 32'(empty), 32'd1);
    chk("fw_end_valid", 32'(rd_valid), 32'd0);
    chk("fw_end_count", 32'(count), 32'd0);
`else
    // 1: three pushes, three pops
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);          // pop while empty is ignored

    // 2: fill to DEPTH, rejected 17th push, drain
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);

    // 3: pointer wrap
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0);

    // 4: push+pop at full, then at empty
    cycle(1'b1, 8'hEE, 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h42, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // 5: asynchronous reset mid-stream with count=7 and rd_valid high
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    mcnt  = 0;
    mwptr = 4'd0;
    mrptr = 4'd0;
    stored.delete();
    exp_out.delete();
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    chk_flags();
    #2 rst_n = 1'b1;
    cycle(1'b1, 8'h77, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
